// File: rtl/ram_dp_sync.sv
// rtl/ram_dp_sync.sv - synchronous dual-port RAM, byte-enabled write port A, read-only port B, clear sequencer
module ram_dp_sync #(
  parameter int ADDR_SIZE   = 10,
  parameter int WORD_SIZE   = 16,
  parameter int MEMORY_SIZE = 1024,
  parameter int RDW_MODE    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   cs_a,
  input  logic                   wr_a,
  input  logic [WORD_SIZE/8-1:0] be_a,
  input  logic [ADDR_SIZE-1:0]   addr_a,
  input  logic [WORD_SIZE-1:0]   data_in_a,
  output logic [WORD_SIZE-1:0]   data_out_a,
  output logic                   valid_a,
  input  logic                   cs_b,
  input  logic [ADDR_SIZE-1:0]   addr_b,
  output logic [WORD_SIZE-1:0]   data_out_b,
  output logic                   valid_b,
  output logic                   busy
);

  localparam int NB    = WORD_SIZE / 8;
  localparam int IDX_W = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
  localparam logic [ADDR_SIZE:0] MEM_LIMIT = (ADDR_SIZE + 1)'(MEMORY_SIZE);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(MEMORY_SIZE - 1);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;

  logic [WORD_SIZE-1:0] mem_q [MEMORY_SIZE];

  logic [0:0]           state_q, state_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] data_out_a_q, data_out_b_q;
  logic                 valid_a_q, valid_b_q;

  logic                 idle;
  logic                 a_in_range, b_in_range;
  logic [IDX_W-1:0]     a_idx, b_idx;
  logic                 rd_a_en, rd_b_en, wr_a_en;
  logic [WORD_SIZE-1:0] rd_a_d, rd_b_d;

  logic                 we;
  logic [IDX_W-1:0]     w_idx;
  logic [WORD_SIZE-1:0] w_data;
  logic [NB-1:0]        w_be;

  assign idle       = (state_q == S_IDLE);
  assign a_in_range = ({1'b0, addr_a} < MEM_LIMIT);
  assign b_in_range = ({1'b0, addr_b} < MEM_LIMIT);
  assign a_idx      = addr_a[IDX_W-1:0];
  assign b_idx      = addr_b[IDX_W-1:0];
  assign rd_a_en    = idle && cs_a && !wr_a;
  assign rd_b_en    = idle && cs_b;
  assign wr_a_en    = idle && cs_a && wr_a && a_in_range;

  // The clear sequencer borrows the single write port while busy.
  always_comb begin
    we     = 1'b0;
    w_idx  = a_idx;
    w_data = data_in_a;
    w_be   = be_a;
    if (!rst) begin
      if (!idle) begin
        we     = 1'b1;
        w_idx  = cnt_q;
        w_data = '0;
        w_be   = '1;
      end else if (wr_a_en) begin
        we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (w_be[i]) mem_q[w_idx][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!idle) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_IDX) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    end else if (clr) begin
      state_d = S_CLEAR;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Port B sees the pre-write word; RDW_MODE=1 overlays the bytes port A is writing.
  always_comb begin
    rd_a_d = a_in_range ? mem_q[a_idx] : '0;
    rd_b_d = b_in_range ? mem_q[b_idx] : '0;
    if (RDW_MODE == 1 && wr_a_en && (addr_a == addr_b)) begin
      for (int i = 0; i < NB; i++) begin
        if (be_a[i]) rd_b_d[8*i +: 8] = data_in_a[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_a_q <= '0;
      data_out_b_q <= '0;
      valid_a_q    <= 1'b0;
      valid_b_q    <= 1'b0;
    end else begin
      valid_a_q <= rd_a_en;
      valid_b_q <= rd_b_en;
      if (rd_a_en) data_out_a_q <= rd_a_d;
      if (rd_b_en) data_out_b_q <= rd_b_d;
    end
  end

  assign data_out_a = data_out_a_q;
  assign data_out_b = data_out_b_q;
  assign valid_a    = valid_a_q;
  assign valid_b    = valid_b_q;
  assign busy       = ~idle;

endmodule

// File: tb/tb_ram_dp_sync.sv
// tb/tb_ram_dp_sync.sv - self-checking bench for ram_dp_sync
// Two instances: dut0 (1024 words, old-data RDW), dut1 (1000 words, new-data RDW).
module tb_ram_dp_sync;

  logic        clk;
  logic        rst, clr, cs_a, wr_a, cs_b;
  logic [1:0]  be_a;
  logic [9:0]  addr_a, addr_b;
  logic [15:0] din_a;

  logic [15:0] da [2];
  logic [15:0] db [2];
  logic        va [2];
  logic        vb [2];
  logic        bsy [2];

  int total = 0;
  int bad   = 0;

  logic [15:0] mem_m [2][1024];
  int          clear_left [2];
  logic [15:0] e_da [2];
  logic [15:0] e_db [2];
  logic        e_va [2];
  logic        e_vb [2];
  int          blen [2];

  ram_dp_sync #(.ADDR_SIZE(10), .WORD_SIZE(16), .MEMORY_SIZE(1024), .RDW_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .clr(clr),
    .cs_a(cs_a), .wr_a(wr_a), .be_a(be_a), .addr_a(addr_a), .data_in_a(din_a),
    .data_out_a(da[0]), .valid_a(va[0]),
    .cs_b(cs_b), .addr_b(addr_b), .data_out_b(db[0]), .valid_b(vb[0]),
    .busy(bsy[0])
  );

  ram_dp_sync #(.ADDR_SIZE(10), .WORD_SIZE(16), .MEMORY_SIZE(1000), .RDW_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr),
    .cs_a(cs_a), .wr_a(wr_a), .be_a(be_a), .addr_a(addr_a), .data_in_a(din_a),
    .data_out_a(da[1]), .valid_a(va[1]),
    .cs_b(cs_b), .addr_b(addr_b), .data_out_b(db[1]), .valid_b(vb[1]),
    .busy(bsy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ms(input int k);
    return (k == 0) ? 1024 : 1000;
  endfunction

  function automatic logic [15:0] mrd(input int k, input logic [9:0] a);
    return (int'(a) < ms(k)) ? mem_m[k][a] : 16'h0000;
  endfunction

  task automatic model_zero(input int k);
    for (int i = 0; i < 1024; i++) mem_m[k][i] = 16'h0000;
  endtask

  // Reference: a clear empties memory as a whole and blocks ports for ms(k) edges.
  task automatic model_edge();
    logic [15:0] old_b;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        e_da[k] = 16'h0; e_db[k] = 16'h0; e_va[k] = 1'b0; e_vb[k] = 1'b0;
        clear_left[k] = ms(k);
        model_zero(k);
      end else if (clear_left[k] > 0) begin
        clear_left[k]--;
        e_va[k] = 1'b0; e_vb[k] = 1'b0;
      end else begin
        old_b = mrd(k, addr_b);
        e_va[k] = cs_a && !wr_a;
        if (e_va[k]) e_da[k] = mrd(k, addr_a);
        e_vb[k] = cs_b;
        if (cs_b) begin
          e_db[k] = old_b;
          if (k == 1 && cs_a && wr_a && addr_a == addr_b && int'(addr_a) < ms(k)) begin
            if (be_a[0]) e_db[k][7:0]  = din_a[7:0];
            if (be_a[1]) e_db[k][15:8] = din_a[15:8];
          end
        end
        if (cs_a && wr_a && int'(addr_a) < ms(k)) begin
          if (be_a[0]) mem_m[k][addr_a][7:0]  = din_a[7:0];
          if (be_a[1]) mem_m[k][addr_a][15:8] = din_a[15:8];
        end
        if (clr) begin
          clear_left[k] = ms(k);
          model_zero(k);
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rst = 1'b0; clr = 1'b0; cs_a = 1'b0; wr_a = 1'b0; cs_b = 1'b0;
    be_a = 2'b00; addr_a = '0; addr_b = '0; din_a = '0;
  endtask

  task automatic wr(input logic [9:0] a, input logic [15:0] d, input logic [1:0] be);
    idle_in();
    cs_a = 1'b1; wr_a = 1'b1; addr_a = a; din_a = d; be_a = be;
    tick();
    idle_in();
  endtask

  task automatic wait_clear();
    idle_in();
    blen[0] = 0; blen[1] = 0;
    for (int t = 1; t <= 1200; t++) begin
      tick();
      for (int k = 0; k < 2; k++) if (blen[k] == 0 && bsy[k] === 1'b0) blen[k] = t;
      if (blen[0] != 0 && blen[1] != 0) break;
    end
  endtask

  task automatic test_reset();
    logic [9:0] rd_addrs [3];
    rd_addrs = '{10'd0, 10'd511, 10'd1023};
    idle_in(); rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_clear();
    wr(10'd0, 16'hFFFF, 2'b11); wr(10'd511, 16'hFFFF, 2'b11);
    wr(10'd999, 16'hFFFF, 2'b11); wr(10'd1023, 16'hFFFF, 2'b11);
    rst = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({bsy[k], va[k], vb[k], da[k], db[k]} !== {1'b1, 1'b0, 1'b0, 16'h0, 16'h0}) begin
        bad++;
        $display("FAIL reset_state dut%0d: got busy=%b va=%b vb=%b da=%h db=%h want 1 0 0 0000 0000",
                 k, bsy[k], va[k], vb[k], da[k], db[k]);
      end
    end
    tick();
    rst = 1'b0;
    wait_clear();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (blen[k] != ms(k)) begin
        bad++;
        $display("FAIL reset_clear_len dut%0d: got %0d want %0d", k, blen[k], ms(k));
      end
    end
    for (int i = 0; i < 3; i++) begin
      cs_a = 1'b1; cs_b = 1'b1; addr_a = rd_addrs[i]; addr_b = rd_addrs[i];
      tick();
      idle_in();
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({va[k], vb[k], da[k], db[k]} !== {1'b1, 1'b1, 16'h0, 16'h0}) begin
          bad++;
          $display("FAIL reset_read dut%0d addr=%0d: got va=%b vb=%b da=%h db=%h want 1 1 0000 0000",
                   k, rd_addrs[i], va[k], vb[k], da[k], db[k]);
        end
      end
    end
  endtask

  task automatic test_byte_en();
    wr(10'd5, 16'hABCD, 2'b11);
    cs_a = 1'b1; wr_a = 1'b1; addr_a = 10'd5; din_a = 16'h1234; be_a = 2'b01;
    tick();
    idle_in();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (va[k] !== 1'b0) begin
        bad++;
        $display("FAIL write_valid dut%0d: got %b want 0", k, va[k]);
      end
    end
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) wr(10'd5, 16'hFFFF, 2'b00);
      cs_a = 1'b1; addr_a = 10'd5;
      tick();
      idle_in();
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({va[k], da[k]} !== {1'b1, 16'hAB34}) begin
          bad++;
          $display("FAIL byte_en pass%0d dut%0d: got va=%b da=%h want 1 ab34", pass, k, va[k], da[k]);
        end
      end
    end
  endtask

  task automatic test_latency();
    for (int a = 0; a <= 16; a++) wr(10'(a), 16'(a * 2), 2'b11);
    cs_a = 1'b1; addr_a = 10'd3; cs_b = 1'b1; addr_b = 10'd16;
    tick();
    idle_in();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({va[k], vb[k], da[k], db[k]} !== {1'b1, 1'b1, 16'd6, 16'd32}) begin
        bad++;
        $display("FAIL latency dut%0d: got va=%b vb=%b da=%h db=%h want 1 1 0006 0020",
                 k, va[k], vb[k], da[k], db[k]);
      end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({va[k], vb[k], da[k], db[k]} !== {1'b0, 1'b0, 16'd6, 16'd32}) begin
        bad++;
        $display("FAIL hold dut%0d: got va=%b vb=%b da=%h db=%h want 0 0 0006 0020",
                 k, va[k], vb[k], da[k], db[k]);
      end
    end
  endtask

  task automatic test_collision();
    wr(10'd7, 16'h00FF, 2'b11);
    cs_a = 1'b1; wr_a = 1'b1; addr_a = 10'd7; din_a = 16'h5500; be_a = 2'b10;
    cs_b = 1'b1; addr_b = 10'd7;
    tick();
    idle_in();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({vb[k], db[k]} !== {1'b1, (k == 0) ? 16'h00FF : 16'h55FF}) begin
        bad++;
        $display("FAIL collision dut%0d: got vb=%b db=%h want 1 %h", k, vb[k], db[k],
                 (k == 0) ? 16'h00FF : 16'h55FF);
      end
    end
    cs_b = 1'b1; addr_b = 10'd7;
    tick();
    idle_in();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({vb[k], db[k]} !== {1'b1, 16'h55FF}) begin
        bad++;
        $display("FAIL after_collision dut%0d: got vb=%b db=%h want 1 55ff", k, vb[k], db[k]);
      end
    end
  endtask

  task automatic test_clr();
    wr(10'd20, 16'hBEEF, 2'b11);
    clr = 1'b1; cs_a = 1'b1; addr_a = 10'd20;
    tick();
    idle_in();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({bsy[k], va[k], da[k]} !== {1'b1, 1'b1, 16'hBEEF}) begin
        bad++;
        $display("FAIL clr_start dut%0d: got busy=%b va=%b da=%h want 1 1 beef", k, bsy[k], va[k], da[k]);
      end
    end
    cs_a = 1'b1; wr_a = 1'b1; be_a = 2'b11; addr_a = 10'd21; din_a = 16'h7777;
    cs_b = 1'b1; addr_b = 10'd20;
    tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({va[k], vb[k], da[k]} !== {1'b0, 1'b0, 16'hBEEF}) begin
        bad++;
        $display("FAIL busy_ignore dut%0d: got va=%b vb=%b da=%h want 0 0 beef", k, va[k], vb[k], da[k]);
      end
    end
    wait_clear();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (blen[k] + 1 != ms(k)) begin
        bad++;
        $display("FAIL clr_len dut%0d: got %0d want %0d", k, blen[k] + 1, ms(k));
      end
    end
    cs_a = 1'b1; addr_a = 10'd20; cs_b = 1'b1; addr_b = 10'd21;
    tick();
    idle_in();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({va[k], vb[k], da[k], db[k]} !== {1'b1, 1'b1, 16'h0, 16'h0}) begin
        bad++;
        $display("FAIL clr_zero dut%0d: got va=%b vb=%b da=%h db=%h want 1 1 0000 0000",
                 k, va[k], vb[k], da[k], db[k]);
      end
    end
    // Reset partway into a clear must restart the full sequence.
    wr(10'd30, 16'h1357, 2'b11);
    clr = 1'b1;
    tick();
    idle_in();
    repeat (299) tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (bsy[k] !== 1'b1) begin
        bad++;
        $display("FAIL midclear_busy dut%0d: got %b want 1", k, bsy[k]);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_clear();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (blen[k] != ms(k)) begin
        bad++;
        $display("FAIL midclear_len dut%0d: got %0d want %0d", k, blen[k], ms(k));
      end
    end
    cs_a = 1'b1; addr_a = 10'd30; cs_b = 1'b1; addr_b = 10'd16;
    tick();
    idle_in();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({va[k], vb[k], da[k], db[k]} !== {1'b1, 1'b1, 16'h0, 16'h0}) begin
        bad++;
        $display("FAIL midclear_zero dut%0d: got va=%b vb=%b da=%h db=%h want 1 1 0000 0000",
                 k, va[k], vb[k], da[k], db[k]);
      end
    end
  endtask

  task automatic test_out_of_range();
    wr(10'd999, 16'h2222, 2'b11);
    wr(10'd1010, 16'h1111, 2'b11);
    cs_a = 1'b1; addr_a = 10'd1010; cs_b = 1'b1; addr_b = 10'd999;
    tick();
    idle_in();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({va[k], vb[k], da[k], db[k]} !== {1'b1, 1'b1, (k == 0) ? 16'h1111 : 16'h0000, 16'h2222}) begin
        bad++;
        $display("FAIL out_of_range dut%0d: got va=%b vb=%b da=%h db=%h want 1 1 %h 2222",
                 k, va[k], vb[k], da[k], db[k], (k == 0) ? 16'h1111 : 16'h0000);
      end
    end
  endtask

  function automatic logic [9:0] raddr();
    if ($urandom_range(0, 2) < 2) return 10'($urandom_range(0, 15));
    return 10'($urandom_range(990, 1023));
  endfunction

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      cs_a   = $urandom_range(0, 3) != 0;
      wr_a   = $urandom_range(0, 1) == 1;
      be_a   = 2'($urandom_range(0, 3));
      addr_a = raddr();
      din_a  = 16'($urandom());
      cs_b   = $urandom_range(0, 3) != 0;
      addr_b = ($urandom_range(0, 1) == 1) ? addr_a : raddr();
      tick();
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({bsy[k], va[k], vb[k], da[k], db[k]} !==
            {(clear_left[k] > 0), e_va[k], e_vb[k], e_da[k], e_db[k]}) begin
          bad++;
          $display("FAIL random dut%0d n=%0d: got busy=%b va=%b vb=%b da=%h db=%h want %b %b %b %h %h",
                   k, n, bsy[k], va[k], vb[k], da[k], db[k],
                   (clear_left[k] > 0), e_va[k], e_vb[k], e_da[k], e_db[k]);
        end
      end
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    test_reset();
    test_byte_en();
    test_latency();
    test_collision();
    test_out_of_range();
    test_random();
    test_clr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_dp_sync.md
Name: ram_dp_sync

Overview:
- Parametrised synchronous dual-port RAM; next generation of the team's single-port asynchronous-read RAM.
- Port A: read/write with per-byte write enables. Port B: read-only.
- Both ports have registered 1-cycle read latency with valid flags, plus a configurable read-during-write policy.
- A built-in clear sequencer zeroes the whole array after reset or on request. Used as scratch/buffer memory in datapath blocks.

Parameters:
- ADDR_SIZE, 10, address width of both ports.
- WORD_SIZE, 16, data width; must be a multiple of 8.
- MEMORY_SIZE, 1024, number of words; must be <= 2**ADDR_SIZE.
- RDW_MODE, 0, port-B read of the address port A writes in the same cycle: 0 = old data, 1 = new (merged) data.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- clr  in  1  one-cycle pulse; starts a full-array clear (ignored while busy).
- cs_a  in  1  port A select.
- wr_a  in  1  port A write (1) / read (0); qualified by cs_a.
- be_a  in  WORD_SIZE/8  port A byte enables; bit i covers data bits [8i+7:8i].
- addr_a  in  ADDR_SIZE  port A address.
- data_in_a  in  WORD_SIZE  port A write data.
- data_out_a  out  WORD_SIZE  port A read data, registered.
- valid_a  out  1  data_out_a updated this cycle.
- cs_b  in  1  port B read select.
- addr_b  in  ADDR_SIZE  port B address.
- data_out_b  out  WORD_SIZE  port B read data, registered.
- valid_b  out  1  data_out_b updated this cycle.
- busy  out  1  clear sequence in progress; all port requests ignored.

Behaviour:
- Reset (rst=1 at edge):
  - data_out_a, data_out_b = 0; valid_a, valid_b = 0; busy = 1.
  - FSM enters CLEAR with clear counter = 0.
  - Reset mid-clear restarts the clear from address 0.
- FSM states: CLEAR and IDLE.
  - CLEAR: each cycle writes 0 to mem[counter], counter += 1. After writing MEMORY_SIZE-1, go to IDLE; busy = 0 from the next cycle.
  - Clear length: exactly MEMORY_SIZE cycles after the first cycle with rst=0.
  - IDLE: clr=1 moves to CLEAR with counter = 0 and busy = 1 next cycle. Any port request in that same cycle is still serviced.
- While busy: cs_a and cs_b are ignored, valid_a and valid_b stay 0, data outputs hold their value.
- Port A write (IDLE, cs_a=1, wr_a=1):
  - Only bytes with be_a[i]=1 are updated at the edge.
  - be_a=0 is a legal no-op.
  - valid_a = 0 next cycle; data_out_a holds.
- Port A read (IDLE, cs_a=1, wr_a=0): data_out_a = mem[addr_a] and valid_a = 1 on the next cycle (latency 1).
- Port B read (IDLE, cs_b=1): same timing as port A read, independent of port A.
- No select on a port: valid = 0 next cycle; data_out holds its last value.
- Collision (A writes and B reads the same address in the same cycle):
  - RDW_MODE=0: data_out_b = pre-write word.
  - RDW_MODE=1: data_out_b = pre-write word with the enabled bytes replaced by data_in_a.
- Reads one cycle after a write return the written data regardless of RDW_MODE.
- Out-of-range address (>= MEMORY_SIZE): writes are dropped; reads return 0 with valid = 1.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset/clear:
  - Preload via writes, then hold rst=1 for 2 cycles and release.
  - busy must stay 1 for exactly 1024 cycles, then drop.
  - Reading addresses 0, 511, 1023 on both ports returns 0x0000 with valid=1 one cycle later.
- Byte enables:
  - Write 0xABCD to addr 5 with be_a=2'b11, then 0x1234 with be_a=2'b01.
  - Port A read of addr 5 returns 0xAB34; a write with be_a=2'b00 leaves 0xAB34.
- Latency and independence:
  - Write k*2 to addr k for k=0..16.
  - Read A at addr 3 and B at addr 16 in the same cycle: next cycle data_out_a=6, data_out_b=32, both valid=1.
  - Cycle after that with no select: both valid=0, data held.
- Collision, RDW_MODE=0 vs 1:
  - addr 7 holds 0x00FF; A writes 0x5500 with be_a=2'b10 while B reads addr 7.
  - B returns 0x00FF for RDW_MODE=0 and 0x55FF for RDW_MODE=1.
  - The following B read returns 0x55FF in both modes.
- clr pulse and mid-clear reset:
  - Pulse clr in IDLE: busy=1 for 1024 cycles. A request issued during busy yields valid=0 and no memory change.
  - Assert rst at clear cycle 300: a fresh full 1024-cycle clear follows and all words read 0.
- Out-of-range (MEMORY_SIZE=1000):
  - Write 0x1111 to addr 1010, then read addr 1010 → 0x0000 with valid=1.
  - addr 999 remains unaffected.
